drm_34x256_fifo_ctrl: RTL

DRM_34X256_FIFO_CTRL -- requirements
Module: drm_34x256_fifo_ctrl

---
 rtl/drm_34x256_fifo_ctrl_pkg.sv | 12 +
 rtl/drm_34x256_fifo_ctrl_if.sv | 31 +++
 rtl/drm_34x256_fifo_ctrl_drm.sv | 38 +++
 rtl/drm_34x256_fifo_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/drm_34x256_fifo_ctrl_pkg.sv
// Shared constants and types for the 34x256 DRM-backed synchronous FIFO.
package drm_34x256_fifo_ctrl_pkg;

  localparam int DATA_W       = 34;
  localparam int ADDR_W       = 8;
  localparam int FIFO_DEPTH   = 1 << ADDR_W;
  localparam int AFULL_TH_DEF  = 240;
  localparam int AEMPTY_TH_DEF = 8;

  typedef logic [ADDR_W:0] count_t;

endpackage

// File: rtl/drm_34x256_fifo_ctrl_if.sv
// Push/pop handshake, status flags and error controls of the FIFO.
interface drm_34x256_fifo_ctrl_if;
  import drm_34x256_fifo_ctrl_pkg::*;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  count_t            count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/drm_34x256_fifo_ctrl_drm.sv
// Behavioural model of the 34x256 simple dual-port DRM macro with a registered read port.
module drm_34x256
  import drm_34x256_fifo_ctrl_pkg::*;
(
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write port; array contents survive reset.
  always_ff @(posedge wr_clk) begin
    if (wr_en && !wr_rst) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port output register, holds its value between reads.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/drm_34x256_fifo_ctrl.sv
// Synchronous FIFO controller around the 34x256 DRM: pointers, occupancy, registered flags.
module drm_34x256_fifo_ctrl #(
  parameter int DATA_W    = drm_34x256_fifo_ctrl_pkg::DATA_W,
  parameter int ADDR_W    = drm_34x256_fifo_ctrl_pkg::ADDR_W,
  parameter int AFULL_TH  = drm_34x256_fifo_ctrl_pkg::AFULL_TH_DEF,
  parameter int AEMPTY_TH = drm_34x256_fifo_ctrl_pkg::AEMPTY_TH_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  drm_34x256_fifo_ctrl_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_s;
  logic              unf_s;
  logic              full_r;
  logic              empty_r;
  logic              afull_r;
  logic              aempty_r;
  logic              rd_valid_r;
  logic              ovf_r;
  logic              unf_r;
  logic              ram_rst_s;
  logic [DATA_W-1:0] ram_rd_data_s;

  // Accept decisions, next occupancy and sticky error next-state.
  always_comb begin
    push_s  = bus.wr_en & ~full_r;
    pop_s   = bus.rd_en & ~empty_r;
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
    // A fresh error event wins over a coincident clear.
    ovf_s = (bus.wr_en & full_r)  | (ovf_r & ~bus.clr_err);
    unf_s = (bus.rd_en & empty_r) | (unf_r & ~bus.clr_err);
  end

  // Pointer, occupancy and flag registers; flags derive from next count so they track count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      afull_r    <= 1'b0;
      aempty_r   <= 1'b1;
      rd_valid_r <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      count_r    <= count_s;
      full_r     <= (count_s == CNT_W'(DEPTH));
      empty_r    <= (count_s == CNT_W'(0));
      afull_r    <= (count_s >= CNT_W'(AFULL_TH));
      aempty_r   <= (count_s <= CNT_W'(AEMPTY_TH));
      rd_valid_r <= pop_s;
      ovf_r      <= ovf_s;
      unf_r      <= unf_s;
    end
  end

  assign ram_rst_s = ~rst_n;

  drm_34x256 u_drm (
    .wr_clk  (clk),
    .wr_rst  (ram_rst_s),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.wr_data),
    .rd_clk  (clk),
    .rd_rst  (ram_rst_s),
    .rd_en   (pop_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_rd_data_s)
  );

  // The macro's read register already resets to zero and holds between pops.
  assign bus.rd_data      = ram_rd_data_s;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule
